// File: rtl/div32x32_seq.sv
// Sequential unsigned 32/32 restoring divider, one quotient bit per clock.
// Shares the multiplier's start/busy handshake; b==0 and a<b finish in one cycle.
module div32x32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] dvd;       // dividend, shifted out MSB first
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        fast;
    logic        accept;
    logic        last;
    logic [32:0] partial;
    logic [32:0] trial;

    // DONE behaves like IDLE, so a held start is taken on the edge after busy falls
    assign accept  = (state != DIV) && start;
    assign last    = fast || (cnt == 5'd31);
    assign partial = {remainder, dvd[31]};
    assign trial   = partial - {1'b0, dvs};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? DIV : IDLE;
            DIV:        state_nxt = last ? DONE : DIV;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DIV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            fast        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd         <= a;
            dvs         <= b;
            cnt         <= '0;
            fast        <= (b == 32'd0) || (a < b);
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == DIV) begin
            cnt <= cnt + 5'd1;
            if (fast) begin
                remainder <= dvd;
                if (dvs == 32'd0) begin
                    quotient    <= 32'hFFFF_FFFF;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= '0;
                end
            end else begin
                dvd <= {dvd[30:0], 1'b0};
                // partial < 2*b, so bit 32 of the trial is set exactly when it went negative
                if (!trial[32]) begin
                    remainder <= trial[31:0];
                    quotient  <= {quotient[30:0], 1'b1};
                end else begin
                    remainder <= partial[31:0];
                    quotient  <= {quotient[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_div32x32_seq.sv
// Randomized scoreboard bench for div32x32_seq: driver pushes expected results,
// a negedge monitor pops and compares each time busy falls.
module tb_div32x32_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   in_op = 0;
    int   blen = 0;

    div32x32_seq dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic division with the defined b==0 result
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.a = x; e.b = y;
        if (y == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = x; e.dz = 1'b1; e.len = 1;
        end else begin
            e.q = x / y; e.r = x % y; e.dz = 1'b0;
            e.len = (x < y) ? 1 : 32;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            in_op = 0;
        end else if (busy && !in_op) begin
            in_op = 1;
            blen = 1;
            chk("cleared_q_after_accept", {32'd0, quotient}, 64'd0);
            chk("cleared_r_after_accept", {32'd0, remainder}, 64'd0);
            chk("cleared_dz_after_accept", {63'd0, div_by_zero}, 64'd0);
        end else if (busy) begin
            blen++;
        end else if (in_op) begin
            in_op = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", {32'd0, quotient}, {32'd0, e.q});
                chk("remainder", {32'd0, remainder}, {32'd0, e.r});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
                chk("busy_length", 64'(blen), 64'(e.len));
                if (e.b != 0) begin
                    chk("invariant", 64'(quotient) * 64'(e.b) + 64'(remainder), {32'd0, e.a});
                    chk("rem_lt_b", {63'd0, remainder < e.b}, 64'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin tick(); n++; end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // One operation: inputs scrambled every busy cycle; optional stray starts on cycles 5 and 32
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit stray);
        int n;
        wait_idle();
        start = 1'b1; a = x; b = y;
        exp_q.push_back(model(x, y));
        tick();
        n = 1;
        while (busy && n < 100) begin
            if (stray && (n == 5 || n == 32)) begin
                start = 1'b1; a = 32'd9; b = 32'd3;
            end else begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            tick();
            n++;
        end
        start = 1'b0;
        if (busy) chk("busy_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_q", {32'd0, quotient}, 64'd0);
        chk("reset_r", {32'd0, remainder}, 64'd0);
        chk("reset_dz", {63'd0, div_by_zero}, 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        do_op(32'd100, 32'd7, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(32'd5, 32'd0, 0);
        do_op(32'd3, 32'd10, 0);
        do_op(32'd100, 32'd7, 1);

        // start held through completion: next op must be taken right after busy falls
        wait_idle();
        start = 1'b1; a = 32'd100; b = 32'd7;
        exp_q.push_back(model(32'd100, 32'd7));
        tick();
        a = 32'd20; b = 32'd6;
        exp_q.push_back(model(32'd20, 32'd6));
        wait_idle();
        chk("held_start_gap", {63'd0, busy}, 64'd0);
        tick();
        chk("held_start_accept", {63'd0, busy}, 64'd1);
        start = 1'b0;
        do_op(32'd1000, 32'd3, 0);

        // asynchronous reset in busy cycle 10 abandons the operation
        wait_idle();
        start = 1'b1; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_q", {32'd0, quotient}, 64'd0);
        chk("async_rst_r", {32'd0, remainder}, 64'd0);
        chk("async_rst_dz", {63'd0, div_by_zero}, 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        do_op(32'd50, 32'd5, 0);

        for (int i = 0; i < 1000; i++) do_op(pick(), pick(), 0);

        wait_idle();
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
